// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the MIPS pipeline front end.
//   - PCSRC_* : next-PC select codes driven by the ID stage
//   - INS_NOP : instruction word that stands for a bubble
//   - fetch_state_t : IF-stage FSM encoding (FETCH / HOLD)
// -----------------------------------------------------------------------------
package pipe_pkg;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;  // pc + 4
  localparam logic [1:0] PCSRC_BR  = 2'b01;  // branch target
  localparam logic [1:0] PCSRC_JR  = 2'b10;  // register jump target
  localparam logic [1:0] PCSRC_J   = 2'b11;  // jump target

  localparam logic [31:0] INS_NOP = 32'h0000_0000;

  typedef enum logic {
    ST_FETCH = 1'b0,  // requesting imem at pc
    ST_HOLD  = 1'b1   // instruction buffered while ID stalls
  } fetch_state_t;

endpackage

// File: rtl/pipe_npc_mux.sv
// -----------------------------------------------------------------------------
// pipe_npc_mux
// Combinational 4:1 next-PC select, shared by the npc path and the redirect
// capture path of the fetch stage.
// Ports:
//   pcsource  in  [1:0]  select code (see pipe_pkg PCSRC_*)
//   pc4       in  [31:0] sequential target
//   bpc       in  [31:0] branch target
//   rpc       in  [31:0] register jump target
//   jpc       in  [31:0] jump target
//   target    out [31:0] selected next PC
// -----------------------------------------------------------------------------
module pipe_npc_mux
  import pipe_pkg::*;
(
  input  logic [1:0]  pcsource,
  input  logic [31:0] pc4,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  output logic [31:0] target
);

  always_comb begin
    unique case (pcsource)
      PCSRC_SEQ: target = pc4;
      PCSRC_BR:  target = bpc;
      PCSRC_JR:  target = rpc;
      PCSRC_J:   target = jpc;
      default:   target = pc4;
    endcase
  end

endmodule

// File: rtl/pipeif_fetch.sv
// -----------------------------------------------------------------------------
// pipeif_fetch
// Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the PC, selects
// the next PC, and fetches from instruction memory over a req/ack handshake
// that tolerates wait states. Feeds pc4/ins to the IF/ID register; ins is a
// NOP whenever no real instruction is available.
//
// Optional build macro: FETCH_PERF_EN adds fetch_count / wait_count outputs.
//
// Ports:
//   clock       in   system clock, all state on posedge
//   reset       in   synchronous active-high reset
//   wpcir       in   PC write enable from ID hazard unit (0 = stall)
//   pcsource    in   [1:0] next-PC select from ID
//   bpc/rpc/jpc in   [31:0] branch / jr / jump targets
//   imem_req    out  fetch request
//   imem_addr   out  [31:0] fetch address (= pc)
//   imem_ack    in   instruction valid this cycle (may coincide with req)
//   imem_rdata  in   [31:0] instruction word, valid with imem_ack
//   pc          out  [31:0] current fetch PC
//   pc4         out  [31:0] pc + 4 (modulo 2^32)
//   ins         out  [31:0] instruction to IF/ID (NOP when ins_valid = 0)
//   ins_valid   out  ins carries a real instruction
//   fetch_count out  [31:0] accepted instructions   (FETCH_PERF_EN only)
//   wait_count  out  [31:0] FETCH cycles without ack (FETCH_PERF_EN only)
// -----------------------------------------------------------------------------
module pipeif_fetch
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wpcir,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic [31:0] ins,
  output logic        ins_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] wait_count
`endif
);

  fetch_state_t state, state_nxt;
  logic [31:0]  hold_ins;
  logic         redir_valid;
  logic [31:0]  redir_pc;
  logic [31:0]  sel_target;
  logic [31:0]  npc;
  logic         accept;

  assign pc4       = pc + 32'd4;
  assign imem_addr = pc;

  pipe_npc_mux u_npc_mux (
    .pcsource (pcsource),
    .pc4      (pc4),
    .bpc      (bpc),
    .rpc      (rpc),
    .jpc      (jpc),
    .target   (sel_target)
  );

  // A captured redirect outranks whatever ID is driving now: ID only shows
  // the branch decision for one cycle, so later pcsource values belong to
  // the delay slot's successors and must not override it.
  assign npc = redir_valid ? redir_pc : sel_target;

  // FSM next state and outputs.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned; that is what keeps this block from inferring latches.
    state_nxt = state;
    accept    = 1'b0;
    imem_req  = 1'b0;
    ins       = INS_NOP;
    ins_valid = 1'b0;
    if (!reset) begin
      unique case (state)
        ST_FETCH: begin
          imem_req  = 1'b1;
          ins       = imem_ack ? imem_rdata : INS_NOP;
          ins_valid = imem_ack;
          if (imem_ack) begin
            if (wpcir) accept = 1'b1;
            else       state_nxt = ST_HOLD;
          end
        end
        ST_HOLD: begin
          ins       = hold_ins;
          ins_valid = 1'b1;
          if (wpcir) begin
            accept    = 1'b1;
            state_nxt = ST_FETCH;
          end
        end
        default: state_nxt = ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (reset) begin
      state       <= ST_FETCH;
      pc          <= RESET_PC;
      hold_ins    <= INS_NOP;
      redir_valid <= 1'b0;
      redir_pc    <= 32'h0;
    end else begin
      state <= state_nxt;
      if (state == ST_FETCH && imem_ack && !wpcir)
        hold_ins <= imem_rdata;
      if (accept) begin
        pc          <= npc;
        redir_valid <= 1'b0;
      end else if (pcsource != PCSRC_SEQ && !redir_valid) begin
        // First non-sequential decision seen while the stage is stalled is
        // latched and applied at the next accept.
        redir_pc    <= sel_target;
        redir_valid <= 1'b1;
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_count <= 32'h0;
      wait_count  <= 32'h0;
    end else begin
      if (accept)
        fetch_count <= fetch_count + 32'd1;
      if (state == ST_FETCH && !imem_ack)
        wait_count <= wait_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeif_fetch.sv
// -----------------------------------------------------------------------------
// tb_pipeif_fetch
// Self-checking bench for pipeif_fetch. Each step drives one cycle of inputs
// and pushes the expected outputs for that cycle into a scoreboard queue; the
// entry is popped and compared once the combinational outputs settle, before
// the next rising edge. Instruction memory returns a word derived from the
// expected fetch address so delivered instructions are traceable.
// -----------------------------------------------------------------------------
module tb_pipeif_fetch;
  import pipe_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        wpcir;
  logic [1:0]  pcsource;
  logic [31:0] bpc, rpc, jpc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc, pc4, ins;
  logic        ins_valid;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count, wait_count;
`endif

  typedef struct {
    logic        chk_addr;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] ins;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  pipeif_fetch #(.RESET_PC(RESET_PC)) dut (
    .clock      (clock),
    .reset      (reset),
    .wpcir      (wpcir),
    .pcsource   (pcsource),
    .bpc        (bpc),
    .rpc        (rpc),
    .jpc        (jpc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .pc         (pc),
    .pc4        (pc4),
    .ins        (ins),
    .ins_valid  (ins_valid)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count(fetch_count),
    .wait_count (wait_count)
`endif
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'h2001_0000 ^ a;
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: drive at the falling edge, compare 1 time unit later, then
  // let the rising edge commit it. tgt is placed on the bus that ps selects;
  // the other target buses carry decoys.
  task automatic step(input logic rst, input logic ack, input logic wp,
                      input logic [1:0] ps, input logic [31:0] tgt,
                      input logic chk_a, input logic e_req,
                      input logic [31:0] e_addr, input logic e_valid);
    exp_t e, got;
    @(negedge clock);
    reset      = rst;
    imem_ack   = ack;
    wpcir      = wp;
    pcsource   = ps;
    bpc        = (ps == PCSRC_BR) ? tgt : 32'hBAD0_0010;
    rpc        = (ps == PCSRC_JR) ? tgt : 32'hBAD0_0020;
    jpc        = (ps == PCSRC_J)  ? tgt : 32'hBAD0_0030;
    imem_rdata = ack ? word_at(e_addr) : 32'hDEAD_BEEF;
    e.chk_addr = chk_a;
    e.req      = e_req;
    e.addr     = e_addr;
    e.valid    = e_valid;
    e.ins      = e_valid ? word_at(e_addr) : INS_NOP;
    sb_q.push_back(e);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_underflow", 32'd0, 32'd1);
    end else begin
      got = sb_q.pop_front();
      check("imem_req", {31'd0, imem_req}, {31'd0, got.req});
      check("ins_valid", {31'd0, ins_valid}, {31'd0, got.valid});
      check("ins", ins, got.ins);
      if (got.chk_addr) begin
        check("imem_addr", imem_addr, got.addr);
        check("pc", pc, got.addr);
        check("pc4", pc4, got.addr + 32'd4);
      end
    end
  endtask

  initial begin
    reset = 1'b1; wpcir = 1'b1; pcsource = PCSRC_SEQ;
    bpc = '0; rpc = '0; jpc = '0; imem_ack = 1'b0; imem_rdata = '0;

    //   rst ack wp  ps         tgt            chk req addr           valid
    // reset state: no request, bubble
    step(1, 1, 1, PCSRC_SEQ, 32'h0,         0, 0, 32'h0,         0);
    step(1, 1, 1, PCSRC_SEQ, 32'h0,         1, 0, RESET_PC,      0);
    // zero-wait sequential fetch
    step(0, 1, 1, PCSRC_SEQ, 32'h0,         1, 1, 32'h0,         1);
    step(0, 1, 1, PCSRC_SEQ, 32'h0,         1, 1, 32'h4,         1);
    // two wait states at pc=8
    step(0, 0, 1, PCSRC_SEQ, 32'h0,         1, 1, 32'h8,         0);
    step(0, 0, 1, PCSRC_SEQ, 32'h0,         1, 1, 32'h8,         0);
    step(0, 1, 1, PCSRC_SEQ, 32'h0,         1, 1, 32'h8,         1);
    step(0, 1, 1, PCSRC_SEQ, 32'h0,         1, 1, 32'hC,         1);
    // ack at 16 with stall: buffered in HOLD, no request
    step(0, 1, 0, PCSRC_SEQ, 32'h0,         1, 1, 32'h10,        1);
    step(0, 0, 0, PCSRC_SEQ, 32'h0,         1, 0, 32'h10,        1);
    step(0, 0, 0, PCSRC_SEQ, 32'h0,         1, 0, 32'h10,        1);
    step(0, 0, 1, PCSRC_SEQ, 32'h0,         1, 0, 32'h10,        1);
    step(0, 1, 1, PCSRC_SEQ, 32'h0,         1, 1, 32'h14,        1);
    // branch seen for one cycle while delay slot at 24 waits; later live
    // non-sequential selects are ignored until the redirect is consumed
    step(0, 0, 1, PCSRC_BR,  32'h100,       1, 1, 32'h18,        0);
    step(0, 0, 1, PCSRC_J,   32'h300,       1, 1, 32'h18,        0);
    step(0, 1, 1, PCSRC_JR,  32'h500,       1, 1, 32'h18,        1);
    // jr at accept goes straight through
    step(0, 1, 1, PCSRC_JR,  32'h400,       1, 1, 32'h100,       1);
    step(0, 1, 1, PCSRC_J,   32'hFFFF_FFFC, 1, 1, 32'h400,       1);
    // wrap at top of address space
    step(0, 1, 1, PCSRC_SEQ, 32'h0,         1, 1, 32'hFFFF_FFFC, 1);
    step(0, 1, 1, PCSRC_SEQ, 32'h0,         1, 1, 32'h0,         1);
    // capture a redirect in a wait state, then reset on top of it
    step(0, 0, 1, PCSRC_BR,  32'h200,       1, 1, 32'h4,         0);
    step(1, 0, 1, PCSRC_SEQ, 32'h0,         0, 0, 32'h0,         0);
    step(0, 1, 1, PCSRC_SEQ, 32'h0,         1, 1, RESET_PC,      1);
    step(0, 1, 1, PCSRC_SEQ, 32'h0,         1, 1, RESET_PC + 4,  1);

`ifdef FETCH_PERF_EN
    @(negedge clock);
    check("fetch_count", fetch_count, 32'd2);
    check("wait_count", wait_count, 32'd0);
`endif

    check("sb_drained", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeif_fetch.md
Name: pipeif_fetch

Overview:
- Instruction-fetch (IF) stage of the 5-stage MIPS pipeline. Sits directly upstream of the IF/ID pipeline register and feeds its pc4/ins inputs.
- Owns the PC register and next-PC selection (sequential, branch, jr, jump).
- Talks to instruction memory over a req/ack handshake that tolerates wait states.
- When no instruction is available, drives a NOP (32'h0) so the IF/ID register latches a bubble.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clock  in  1  system clock, all state on posedge.
- reset  in  1  synchronous, active-high reset.
- wpcir  in  1  PC write enable from ID hazard unit; 0 = stall.
- pcsource  in  2  next-PC select from ID: 00 pc+4, 01 bpc, 10 rpc (jr), 11 jpc.
- bpc  in  32  branch target.
- rpc  in  32  register jump target.
- jpc  in  32  jump target.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address (= pc).
- imem_ack  in  1  instruction valid this cycle; may assert in the same cycle as req.
- imem_rdata  in  32  instruction word, valid when imem_ack=1.
- pc  out  32  current fetch PC.
- pc4  out  32  pc+4, to IF/ID.
- ins  out  32  instruction to IF/ID (NOP when ins_valid=0).
- ins_valid  out  1  ins carries a real instruction this cycle.

Behaviour:
- Reset (synchronous):
  - pc=RESET_PC, state=FETCH, hold_ins=0, redir_valid=0, redir_pc=0.
  - imem_req is gated to 0 while reset is high; ins=0 and ins_valid=0 while reset is high.
  - An outstanding memory request is abandoned; the memory must tolerate req dropping.
- States:
  - FETCH: imem_req=1, imem_addr=pc.
    - ins = imem_ack ? imem_rdata : 0; ins_valid = imem_ack.
    - imem_ack & wpcir (accept): pc<=npc; clear redir_valid; stay FETCH.
    - imem_ack & !wpcir: hold_ins<=imem_rdata; go HOLD; pc unchanged.
    - !imem_ack: stay FETCH; pc unchanged.
  - HOLD: imem_req=0; ins=hold_ins; ins_valid=1.
    - wpcir=1 (accept): pc<=npc; clear redir_valid; go FETCH.
    - wpcir=0: stay HOLD.
- pc4 = pc+4, combinational, 32-bit modulo; wraps 32'hFFFF_FFFC -> 0.
- npc:
  - redir_valid ? redir_pc : select(pcsource, pc+4, bpc, rpc, jpc).
  - A pending redirect has priority; a live non-00 pcsource seen while redir_valid=1 is ignored.
- Redirect capture (branch-delay-slot preservation):
  - Condition: a cycle with no accept, pcsource!=00 and redir_valid=0.
  - Action: redir_pc<=selected target, redir_valid<=1.
  - First capture wins. This holds the branch decision across wait states, since ID sees the branch for only one cycle.
- Latency: zero-wait memory gives one instruction per cycle. ins is combinational from imem_rdata, so IF/ID latches it at the same edge the PC advances.
- Stall with no ack: stay FETCH, keep requesting the same pc.
- ack with stall: instruction buffered in HOLD; no re-fetch.
- Simultaneous accept and non-00 pcsource: pcsource is used directly for npc; nothing is captured.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - Adds outputs fetch_count[31:0] (accepts) and wait_count[31:0] (FETCH cycles with imem_ack=0).
  - Both are synchronous-reset to 0 and wrap modulo 2^32.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg: PCSRC_SEQ=2'b00, PCSRC_BR=2'b01, PCSRC_JR=2'b10, PCSRC_J=2'b11, INS_NOP=32'h0, FSM state encoding for FETCH/HOLD.
- Sub-module pipe_npc_mux: combinational 4:1 next-PC select. Reused by the redirect capture path and the npc path.

Test Plan:
- Reset then release, imem_ack tied 1, imem_rdata=32'h2001_0005 -> imem_addr 0,4,8,... on consecutive cycles; pc4 = addr+4; ins_valid=1 every cycle.
- imem_ack low for 2 cycles at pc=8 -> imem_addr stays 8 for 3 cycles; ins=0 and ins_valid=0 for the first 2; pc=12 after the ack cycle.
- ack at pc=16 with wpcir=0 for 3 cycles -> HOLD; imem_req=0; ins held at the acked word; pc stays 16; FETCH resumes at 20 after wpcir=1.
- pcsource=01, bpc=32'h100 asserted for one cycle while the delay slot at pc=24 is waiting 2 cycles -> the delay slot is delivered, then imem_addr=32'h100.
- pcsource=10, rpc=32'h400 at accept -> next imem_addr=32'h400. pc=32'hFFFF_FFFC with sequential fetch -> pc4=0, next addr 0.
- reset asserted in a FETCH wait state -> next cycle imem_req=0, ins_valid=0; after release imem_addr=RESET_PC and redir_valid is cleared.
